// File: rtl/multdiv_pw_ctrl.sv
// multdiv_pw_ctrl: P/W stage controller for the iterative mult/div unit.
// Detects a mult/div in DX, latches its operands, pulses the unit's start
// line, stalls the front of the pipe until the result returns, then issues
// a one-cycle register writeback: the result goes to $rd, an exception
// code goes to $r30.
// Optional build macro MD_TIMEOUT_EN: abort BUSY after TIMEOUT cycles
// without md_ready and write back a forced exception.
module multdiv_pw_ctrl #(
  parameter int TIMEOUT = 48,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic [31:0] md_op_a,
  output logic [31:0] md_op_b,
  output logic        pw_stall,
  output logic [31:0] pw_ir,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data
);

  // The counter must be able to hold TIMEOUT without wrapping.
  if ((2 ** CNT_W) <= TIMEOUT) begin : g_cnt_check
    $error("CNT_W too narrow for TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic             op_div_reg;
  logic             exc_reg;
  logic [31:0]      result_reg;
  logic [31:0]      pw_ir_reg;
  logic [31:0]      op_a_reg, op_b_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             is_mult, is_div, is_md;
  logic             timeout_hit;

  // Decode of the instruction currently sitting in DX.
  always_comb begin
    is_mult = (dx_ir[31:27] == 5'b00000) && (dx_ir[6:2] == 5'b00110);
    is_div  = (dx_ir[31:27] == 5'b00000) && (dx_ir[6:2] == 5'b00111);
    is_md   = is_mult || is_div;
  end

`ifdef MD_TIMEOUT_EN
  // Fires in the TIMEOUT-th BUSY cycle (the counter starts at 0 in the first).
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic. The mult/div still held in DX during DONE is not
  // re-detected because detection happens only in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (is_md) state_next = START;
      START:   state_next = BUSY;
      BUSY:    if (md_ready || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand/instruction latch, result capture, BUSY cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      pw_ir_reg  <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      op_div_reg <= 1'b0;
      exc_reg    <= 1'b0;
      result_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (is_md) begin
          pw_ir_reg  <= dx_ir;
          op_a_reg   <= dx_a;
          op_b_reg   <= dx_b;
          op_div_reg <= is_div;
        end
        START: cnt_reg <= '0;
        BUSY: begin
          if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + 1'b1;
          if (md_ready) begin
            result_reg <= md_result;
            exc_reg    <= md_exception;
          end else if (timeout_hit) begin
            exc_reg    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: start pulses, stall and the DONE-cycle writeback request.
  always_comb begin
    ctrl_mult = (state_reg == START) && !op_div_reg;
    ctrl_div  = (state_reg == START) &&  op_div_reg;
    pw_stall  = ((state_reg == IDLE) && is_md) || (state_reg == START) ||
                (state_reg == BUSY);
    md_op_a   = op_a_reg;
    md_op_b   = op_b_reg;
    pw_ir     = pw_ir_reg;
    wb_valid  = 1'b0;
    wb_reg    = 5'd0;
    wb_data   = 32'd0;
    if (state_reg == DONE) begin
      if (exc_reg) begin
        wb_valid = 1'b1;
        wb_reg   = 5'd30;
        wb_data  = op_div_reg ? 32'd5 : 32'd4;
      end else begin
        wb_reg   = pw_ir_reg[26:22];
        wb_data  = result_reg;
        wb_valid = (pw_ir_reg[26:22] != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_multdiv_pw_ctrl.sv
// tb_multdiv_pw_ctrl: directed bench for multdiv_pw_ctrl. Expected start
// pulses and writebacks are queued by the driver and checked by a monitor.
module tb_multdiv_pw_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dx_ir, dx_a, dx_b, md_result;
  logic        md_exception, md_ready;
  logic        ctrl_mult, ctrl_div, pw_stall, wb_valid;
  logic [31:0] md_op_a, md_op_b, pw_ir, wb_data;
  logic [4:0]  wb_reg;

  int n_vec = 0;
  int n_err = 0;

  logic [36:0] wb_q[$];   // {reg, data}
  bit          ctrl_q[$]; // 1 = div, 0 = mult

  localparam logic [31:0] NOP = 32'h0000_0000;

  multdiv_pw_ctrl dut (
    .clock(clock), .reset(reset), .dx_ir(dx_ir), .dx_a(dx_a), .dx_b(dx_b),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .md_op_a(md_op_a),
    .md_op_b(md_op_b), .pw_stall(pw_stall), .pw_ir(pw_ir),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] alu_op);
    return {5'b00000, rd, 5'd1, 5'd2, 5'd0, alu_op, 2'b00};
  endfunction

  // Monitor: every start pulse and every writeback must match the queue head.
  always @(negedge clock) begin
    if (ctrl_mult && ctrl_div) chk("ctrl_both_high", 37'd1, 37'd0);
    if (ctrl_mult || ctrl_div) begin
      if (ctrl_q.size() == 0) chk("ctrl_unexpected", 37'd1, 37'd0);
      else chk("ctrl_op", {36'd0, ctrl_div}, {36'd0, ctrl_q.pop_front()});
    end
    if (wb_valid) begin
      if (wb_q.size() == 0) chk("wb_unexpected", {wb_reg, wb_data}, 37'd0);
      else chk("wb", {wb_reg, wb_data}, wb_q.pop_front());
    end
  end

  // Runs one mult/div from detect through DONE. ready_lat = BUSY cycle in
  // which md_ready pulses (0 = never). busy_len = BUSY cycles to simulate.
  task automatic run_md(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                        input int busy_len, input int ready_lat,
                        input logic [31:0] res, input logic exc,
                        input bit exp_wb, input logic [4:0] exp_reg,
                        input logic [31:0] exp_data, input bit is_div_op);
    int stall_cnt = 0;
    ctrl_q.push_back(is_div_op);
    if (exp_wb) wb_q.push_back({exp_reg, exp_data});
    dx_ir = ir; dx_a = a; dx_b = b;
    for (int cyc = 0; cyc < busy_len + 2; cyc++) begin
      md_ready     = (ready_lat != 0) && (cyc == ready_lat + 1);
      md_result    = md_ready ? res : 32'hDEAD_BEEF;
      md_exception = md_ready ? exc : 1'b0;
      @(negedge clock);
      if (pw_stall) stall_cnt++;
      if (cyc == 1) begin
        chk("md_op_a", {5'd0, md_op_a}, {5'd0, a});
        chk("md_op_b", {5'd0, md_op_b}, {5'd0, b});
        chk("pw_ir", {5'd0, pw_ir}, {5'd0, ir});
      end
      @(posedge clock); #1;
    end
    md_ready = 1'b0; md_exception = 1'b0;
    // DONE cycle: DX still holds the mult/div but the stall has dropped.
    @(negedge clock);
    chk("stall_done", {36'd0, pw_stall}, 37'd0);
    chk("stall_cycles", 37'(stall_cnt), 37'(busy_len + 2));
    @(posedge clock); #1;
    dx_ir = NOP;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; dx_ir = NOP; dx_a = '0; dx_b = '0;
    md_result = '0; md_exception = 1'b0; md_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_pw_ir", {5'd0, pw_ir}, 37'd0);
    chk("rst_op_a", {5'd0, md_op_a}, 37'd0);
    chk("rst_op_b", {5'd0, md_op_b}, 37'd0);
    chk("rst_wb", {3'd0, wb_valid, wb_reg, wb_data}, 37'd0);
    chk("rst_ctrl_stall", {34'd0, ctrl_mult, ctrl_div, pw_stall}, 37'd0);
    @(posedge clock); #1;

    // mult $3,$1,$2: 6*7=42, ready in 17th BUSY cycle -> 19 stall cycles
    run_md(mk(5'd3, 5'b00110), 32'd6, 32'd7, 17, 17, 32'd42, 1'b0,
           1'b1, 5'd3, 32'd42, 1'b0);
    // div $5,$1,$2 with exception -> $r30 = 5
    run_md(mk(5'd5, 5'b00111), 32'd9, 32'd0, 4, 4, 32'd0, 1'b1,
           1'b1, 5'd30, 32'd5, 1'b1);
    // mult with rd=0: no writeback
    run_md(mk(5'd0, 5'b00110), 32'd3, 32'd3, 1, 1, 32'd9, 1'b0,
           1'b0, 5'd0, 32'd0, 1'b0);
    // back-to-back mults
    run_md(mk(5'd7, 5'b00110), 32'd2, 32'd5, 3, 3, 32'd10, 1'b0,
           1'b1, 5'd7, 32'd10, 1'b0);
    run_md(mk(5'd8, 5'b00110), 32'd4, 32'd4, 2, 2, 32'd16, 1'b0,
           1'b1, 5'd8, 32'd16, 1'b0);

    // Reset mid-BUSY, then a stale md_ready two cycles after release.
    ctrl_q.push_back(1'b0);
    dx_ir = mk(5'd9, 5'b00110); dx_a = 32'd11; dx_b = 32'd12;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1; dx_ir = NOP;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_pw_ir", {5'd0, pw_ir}, 37'd0);
    chk("abort_op_a", {5'd0, md_op_a}, 37'd0);
    @(posedge clock); #1;
    md_ready = 1'b1; md_result = 32'd132; md_exception = 1'b0;
    @(posedge clock); #1;
    md_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("abort_idle", {34'd0, pw_stall, wb_valid, ctrl_mult | ctrl_div}, 37'd0);
    end
    @(posedge clock); #1;

`ifdef MD_TIMEOUT_EN
    // Timeout: never ready -> forced exception after 48 BUSY cycles.
    run_md(mk(5'd4, 5'b00110), 32'd1, 32'd1, 48, 0, 32'd0, 1'b0,
           1'b1, 5'd30, 32'd4, 1'b0);
`endif

    repeat (2) @(posedge clock);
    chk("wb_q_drained", 37'(wb_q.size()), 37'd0);
    chk("ctrl_q_drained", 37'(ctrl_q.size()), 37'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
